// File: rtl/round_sequencer.sv
// round_sequencer: one game of the LED memory game, from pattern generation to final score.
// Latency: gen_done->show_start 1 cycle, show_done->inp_start 1 cycle, inp_done->last_win 2 cycles.
// Backpressure: none; start/done are single-cycle pulses, stray done pulses are dropped, abort always wins.
module round_sequencer #(
  parameter int MAX_LEN        = 16,
  parameter int SYM_W          = 3,
  parameter int LEN_L1         = 8,
  parameter int LEN_L2         = 12,
  parameter int LEN_L3         = 16,
  parameter int NUM_ROUNDS     = 10,
  parameter int POINTS         = 10,
  parameter int GAP_CYCLES     = 500,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SCORE_W        = 9
) (
  input  logic                     clk_1,
  input  logic                     rst,
  input  logic [2:0]               level,
  input  logic                     game_start,
  input  logic                     abort,
  output logic                     gen_start,
  input  logic                     gen_done,
  output logic                     show_start,
  input  logic                     show_done,
  output logic                     inp_start,
  input  logic                     inp_done,
  input  logic [MAX_LEN*SYM_W-1:0] pattern,
  input  logic [MAX_LEN*SYM_W-1:0] user_inp,
  output logic [4:0]               round_idx,
  output logic [4:0]               correct_cnt,
  output logic [SCORE_W-1:0]       score,
  output logic                     last_win,
  output logic                     timed_out,
  output logic                     busy,
  output logic                     game_over
);

  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int TMR_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = (TIMEOUT_CYCLES == 0) ? '0 : TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_FULL = '1;

  // Reject parameter sets the counters and score register cannot represent.
  if ((NUM_ROUNDS < 1) || (NUM_ROUNDS > 31)) begin : g_chk_rounds
    $error("round_sequencer: NUM_ROUNDS must be in 1..31");
  end
  if (NUM_ROUNDS * POINTS >= (2 ** SCORE_W)) begin : g_chk_score
    $error("round_sequencer: SCORE_W too narrow for NUM_ROUNDS*POINTS");
  end
  if (GAP_CYCLES < 1) begin : g_chk_gap
    $error("round_sequencer: GAP_CYCLES must be at least 1");
  end
  if ((LEN_L1 > MAX_LEN) || (LEN_L2 > MAX_LEN) || (LEN_L3 > MAX_LEN)) begin : g_chk_len
    $error("round_sequencer: level lengths must not exceed MAX_LEN");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN   = 3'd1,
    ST_SHOW  = 3'd2,
    ST_INPUT = 3'd3,
    ST_CHECK = 3'd4,
    ST_GAP   = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [LEN_W-1:0]    r_len;
  logic [TMR_W-1:0]    r_timer;
  logic                r_force_loss;
  logic [4:0]          r_round_idx;
  logic [4:0]          r_correct_cnt;
  logic [SCORE_W-1:0]  r_score;
  logic                r_last_win;
  logic                r_timed_out;
  logic                r_gen_start;
  logic                r_show_start;
  logic                r_inp_start;

  logic [LEN_W-1:0]    w_len_sel;
  logic                w_level_ok;
  logic                w_new_game;
  logic                w_gen_start_nxt;
  logic                w_show_start_nxt;
  logic                w_inp_start_nxt;
  logic                w_timeout;
  logic                w_to_hit;
  logic                w_gap_end;
  logic                w_last_round;
  logic                w_match;
  logic                w_win;
  logic [4:0]          w_cnt_final;

  // Decode the one-hot level into an active pattern length; anything else is illegal.
  always_comb begin
    w_len_sel  = '0;
    w_level_ok = 1'b0;
    case (level)
      3'b001: begin w_len_sel = LEN_W'(LEN_L1); w_level_ok = 1'b1; end
      3'b010: begin w_len_sel = LEN_W'(LEN_L2); w_level_ok = 1'b1; end
      3'b100: begin w_len_sel = LEN_W'(LEN_L3); w_level_ok = 1'b1; end
      default: begin w_len_sel = '0; w_level_ok = 1'b0; end
    endcase
  end

  // Slot-by-slot compare over the active length only; slots at or beyond len are don't-care.
  always_comb begin
    w_match = 1'b1;
    for (int k = 0; k < MAX_LEN; k++) begin
      if ((k < int'(r_len)) && (pattern[k*SYM_W +: SYM_W] != user_inp[k*SYM_W +: SYM_W])) begin
        w_match = 1'b0;
      end
    end
  end

  assign w_win        = w_match && !r_force_loss;
  assign w_cnt_final  = r_correct_cnt + {4'd0, w_win};
  assign w_last_round = ((r_round_idx + 5'd1) == 5'(NUM_ROUNDS));
  assign w_to_hit     = (TIMEOUT_CYCLES != 0) && (r_timer == TO_LAST);
  assign w_gap_end    = (r_timer == GAP_LAST);

  // State register.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and one-shot start requests; abort overrides every other decision.
  always_comb begin
    w_state_nxt      = r_state;
    w_new_game       = 1'b0;
    w_gen_start_nxt  = 1'b0;
    w_show_start_nxt = 1'b0;
    w_inp_start_nxt  = 1'b0;
    w_timeout        = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (game_start && w_level_ok) begin
          w_state_nxt     = ST_GEN;
          w_new_game      = 1'b1;
          w_gen_start_nxt = 1'b1;
        end
      end
      ST_GEN: begin
        if (gen_done) begin
          w_state_nxt      = ST_SHOW;
          w_show_start_nxt = 1'b1;
        end
      end
      ST_SHOW: begin
        if (show_done) begin
          w_state_nxt     = ST_INPUT;
          w_inp_start_nxt = 1'b1;
        end
      end
      ST_INPUT: begin
        if (inp_done) begin
          w_state_nxt = ST_CHECK;
        end else if (w_to_hit) begin
          w_state_nxt = ST_CHECK;
          w_timeout   = 1'b1;
        end
      end
      ST_CHECK: begin
        w_state_nxt = w_last_round ? ST_DONE : ST_GAP;
      end
      ST_GAP: begin
        if (w_gap_end) begin
          w_state_nxt     = ST_GEN;
          w_gen_start_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (abort) begin
      w_state_nxt      = ST_IDLE;
      w_new_game       = 1'b0;
      w_gen_start_nxt  = 1'b0;
      w_show_start_nxt = 1'b0;
      w_inp_start_nxt  = 1'b0;
      w_timeout        = 1'b0;
    end
  end

  // Register the start pulses so each lands one cycle after the event that caused it.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      r_gen_start  <= 1'b0;
      r_show_start <= 1'b0;
      r_inp_start  <= 1'b0;
    end else begin
      r_gen_start  <= w_gen_start_nxt;
      r_show_start <= w_show_start_nxt;
      r_inp_start  <= w_inp_start_nxt;
    end
  end

  // Shared cycle timer: counts INPUT wait and GAP length, zeroed on INPUT entry and in CHECK.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      r_timer <= '0;
    end else if (abort || w_inp_start_nxt || (r_state == ST_CHECK)) begin
      r_timer <= '0;
    end else if (((r_state == ST_INPUT) || (r_state == ST_GAP)) && (r_timer != TMR_FULL)) begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  // Game bookkeeping: level length, round/correct counters, score and result flags.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      r_len         <= '0;
      r_force_loss  <= 1'b0;
      r_round_idx   <= '0;
      r_correct_cnt <= '0;
      r_score       <= '0;
      r_last_win    <= 1'b0;
      r_timed_out   <= 1'b0;
    end else if (abort) begin
      r_len         <= '0;
      r_force_loss  <= 1'b0;
      r_round_idx   <= '0;
      r_correct_cnt <= '0;
      r_score       <= '0;
      r_last_win    <= 1'b0;
      r_timed_out   <= 1'b0;
    end else begin
      if (w_new_game) begin
        r_len         <= w_len_sel;
        r_round_idx   <= '0;
        r_correct_cnt <= '0;
        r_score       <= '0;
        r_timed_out   <= 1'b0;
      end
      // A timed-out round is remembered until CHECK so it scores as a loss whatever user_inp holds.
      if (w_timeout) begin
        r_force_loss <= 1'b1;
        r_timed_out  <= 1'b1;
      end else if (w_inp_start_nxt) begin
        r_force_loss <= 1'b0;
      end
      if (r_state == ST_CHECK) begin
        r_last_win    <= w_win;
        r_correct_cnt <= w_cnt_final;
        r_round_idx   <= r_round_idx + 5'd1;
        // Score uses the post-round count so it is already valid on the first DONE cycle.
        if (w_last_round) begin
          r_score <= SCORE_W'(w_cnt_final) * SCORE_W'(POINTS);
        end
      end
    end
  end

  assign gen_start   = r_gen_start;
  assign show_start  = r_show_start;
  assign inp_start   = r_inp_start;
  assign round_idx   = r_round_idx;
  assign correct_cnt = r_correct_cnt;
  assign score       = r_score;
  assign last_win    = r_last_win;
  assign timed_out   = r_timed_out;
  assign busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign game_over   = (r_state == ST_DONE);

endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: randomized games against a round-level reference model.
// Latency of every handshake is checked at exact cycle offsets.
// Done pulses are driven by the bench acting as generator, display and input capture.
module tb_round_sequencer;
  localparam int MAX_LEN = 16;
  localparam int SYM_W   = 3;
  localparam int NR      = 3;
  localparam int PTS     = 10;
  localparam int GAP     = 4;
  localparam int TO      = 20;
  localparam int SW      = 9;
  localparam int BW      = MAX_LEN * SYM_W;

  logic          clk_1 = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    level = 3'b000;
  logic          game_start = 1'b0;
  logic          abort = 1'b0;
  logic          gen_done = 1'b0;
  logic          show_done = 1'b0;
  logic          inp_done = 1'b0;
  logic [BW-1:0] pattern = '0;
  logic [BW-1:0] user_inp = '0;
  logic          gen_start, show_start, inp_start;
  logic [4:0]    round_idx, correct_cnt;
  logic [SW-1:0] score;
  logic          last_win, timed_out, busy, game_over;

  round_sequencer #(
    .MAX_LEN(MAX_LEN), .SYM_W(SYM_W), .LEN_L1(8), .LEN_L2(12), .LEN_L3(16),
    .NUM_ROUNDS(NR), .POINTS(PTS), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .SCORE_W(SW)
  ) dut (
    .clk_1(clk_1), .rst(rst), .level(level), .game_start(game_start), .abort(abort),
    .gen_start(gen_start), .gen_done(gen_done), .show_start(show_start), .show_done(show_done),
    .inp_start(inp_start), .inp_done(inp_done), .pattern(pattern), .user_inp(user_inp),
    .round_idx(round_idx), .correct_cnt(correct_cnt), .score(score), .last_win(last_win),
    .timed_out(timed_out), .busy(busy), .game_over(game_over)
  );

  always #5 clk_1 = ~clk_1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state: one entry per game, updated once per round.
  logic [SYM_W-1:0] pat_a [MAX_LEN];
  logic [SYM_W-1:0] usr_a [MAX_LEN];
  int m_len, m_rounds, m_correct;
  bit m_to;

  function automatic int lvl_len(input logic [2:0] lv);
    case (lv)
      3'b001:  return 8;
      3'b010:  return 12;
      3'b100:  return 16;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_win(input int len);
    for (int k = 0; k < len; k++) begin
      if (pat_a[k] != usr_a[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step();
    @(negedge clk_1);
  endtask

  // Start pulses: never two at once, never wider than one cycle.
  logic [2:0] prev_st = 3'b000;
  always @(negedge clk_1) begin
    chk("start_excl", 32'($countones({gen_start, show_start, inp_start}) <= 1), 32'd1);
    chk("start_width", {29'd0, prev_st & {gen_start, show_start, inp_start}}, 32'd0);
    prev_st = {gen_start, show_start, inp_start};
  end

  task automatic start_game(input logic [2:0] lv);
    level = lv;
    game_start = 1'b1;
    step();
    game_start = 1'b0;
    level = 3'($urandom);  // must not matter once the game is running
    m_len = lvl_len(lv);
    m_rounds = 0;
    m_correct = 0;
    m_to = 1'b0;
    chk("gs_gen_start", gen_start, 1);
    chk("gs_round_idx", round_idx, 0);
    chk("gs_correct", correct_cnt, 0);
    chk("gs_score", score, 0);
    chk("gs_timed_out", timed_out, 0);
    chk("gs_busy", busy, 1);
    chk("gs_game_over", game_over, 0);
  endtask

  // Entered with gen_start visible. mode 0: match, 1: mismatch at mslot,
  // 2: inp_done withheld (timeout), 3: inp_done in the timeout cycle with matching input.
  task automatic run_round(input int mode, input int mslot);
    int d;
    bit exp_win;
    if (mslot < 0 || mslot >= m_len) mslot = $urandom_range(0, m_len - 1);
    d = $urandom_range(0, 3);
    repeat (d) step();
    for (int k = 0; k < MAX_LEN; k++) begin
      pat_a[k] = SYM_W'($urandom_range(0, 7));
      pattern[k*SYM_W +: SYM_W] = pat_a[k];
    end
    gen_done = 1'b1;
    step();
    gen_done = 1'b0;
    chk("show_lat", show_start, 1);
    d = $urandom_range(0, 3);
    repeat (d) step();
    show_done = 1'b1;
    step();
    show_done = 1'b0;
    chk("inp_lat", inp_start, 1);
    for (int k = 0; k < MAX_LEN; k++) begin
      usr_a[k] = pat_a[k];
      if (k >= m_len) usr_a[k] = usr_a[k] ^ SYM_W'($urandom_range(1, 7));
    end
    if (mode == 1) usr_a[mslot] = usr_a[mslot] ^ SYM_W'($urandom_range(1, 7));
    for (int k = 0; k < MAX_LEN; k++) user_inp[k*SYM_W +: SYM_W] = usr_a[k];
    if (mode == 2) begin
      repeat (TO) step();
      chk("to_hold", round_idx, m_rounds);
      step();
      exp_win = 1'b0;
      m_to = 1'b1;
    end else if (mode == 3) begin
      repeat (TO - 1) step();
      inp_done = 1'b1;
      step();
      inp_done = 1'b0;
      chk("co_hold", round_idx, m_rounds);
      step();
      exp_win = ref_win(m_len);
    end else begin
      d = $urandom_range(0, 15);
      repeat (d) step();
      inp_done = 1'b1;
      step();
      inp_done = 1'b0;
      chk("chk_hold", round_idx, m_rounds);
      step();
      exp_win = ref_win(m_len);
    end
    m_rounds++;
    m_correct += int'(exp_win);
    chk("round_idx", round_idx, m_rounds);
    chk("correct_cnt", correct_cnt, m_correct);
    chk("last_win", last_win, exp_win);
    chk("timed_out", timed_out, m_to);
    if (m_rounds == NR) begin
      chk("done_game_over", game_over, 1);
      chk("done_busy", busy, 0);
      chk("done_score", score, m_correct * PTS);
    end else begin
      repeat (GAP - 1) step();
      chk("gap_early", gen_start, 0);
      chk("gap_busy", busy, 1);
      step();
      chk("gap_gen", gen_start, 1);
    end
  endtask

  initial begin
    int starts;
    logic [2:0] lv;
    #2 rst = 1'b0;
    #10;
    chk("rst_outs", {6'd0, gen_start, show_start, inp_start, round_idx, correct_cnt, score,
                     last_win, timed_out, busy, game_over}, 32'd0);
    step();
    rst = 1'b1;
    step();

    // Level 1: only slots 0..7 matter, upper slots always differ.
    start_game(3'b001);
    for (int r = 0; r < NR; r++) run_round(0, -1);
    chk("g1_score", score, 30);

    // Level 3 restarted from DONE; round 2 differs only in slot 15.
    start_game(3'b100);
    run_round(0, -1);
    run_round(1, 15);
    chk("g2_slot15_loss", last_win, 0);
    run_round(0, -1);
    chk("g2_score", score, (NR - 1) * PTS);

    // Coincident inp_done/timeout, then a real timeout, then a random round.
    start_game(3'b010);
    run_round(3, -1);
    run_round(2, -1);
    run_round($urandom_range(0, 1), -1);

    // Fully random games.
    for (int g = 0; g < 3; g++) begin
      lv = 3'b001 << $urandom_range(0, 2);
      start_game(lv);
      for (int r = 0; r < NR; r++) run_round($urandom_range(0, 1), -1);
    end

    // Abort mid-SHOW in round 2; later done pulses must be ignored.
    start_game(3'b010);
    run_round(0, -1);
    gen_done = 1'b1;
    step();
    gen_done = 1'b0;
    chk("ab_show", show_start, 1);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_round", round_idx, 0);
    chk("ab_correct", correct_cnt, 0);
    chk("ab_score", score, 0);
    chk("ab_last_win", last_win, 0);
    chk("ab_game_over", game_over, 0);
    starts = 0;
    show_done = 1'b1;
    step();
    show_done = 1'b0;
    gen_done = 1'b1;
    inp_done = 1'b1;
    step();
    gen_done = 1'b0;
    inp_done = 1'b0;
    repeat (8) begin
      starts += int'(gen_start) + int'(show_start) + int'(inp_start);
      step();
    end
    chk("ab_quiet", starts, 0);
    chk("ab_idle", busy, 0);
    // abort beats a simultaneous legal game_start
    level = 3'b001;
    abort = 1'b1;
    game_start = 1'b1;
    step();
    abort = 1'b0;
    game_start = 1'b0;
    chk("ab_prio_gen", gen_start, 0);
    chk("ab_prio_busy", busy, 0);

    // Asynchronous reset while waiting in INPUT of round 2.
    start_game(3'b001);
    run_round(0, -1);
    gen_done = 1'b1;
    step();
    gen_done = 1'b0;
    show_done = 1'b1;
    step();
    show_done = 1'b0;
    chk("pr_inp_start", inp_start, 1);
    step();
    chk("pr_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst", {6'd0, gen_start, show_start, inp_start, round_idx, correct_cnt, score,
                      last_win, timed_out, busy, game_over}, 32'd0);
    step();
    rst = 1'b1;
    step();

    // Non-one-hot level is ignored.
    level = 3'b011;
    game_start = 1'b1;
    step();
    game_start = 1'b0;
    chk("ill_gen", gen_start, 0);
    chk("ill_busy", busy, 0);
    starts = 0;
    repeat (4) begin
      step();
      starts += int'(gen_start);
    end
    chk("ill_quiet", starts, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
